// File: rtl/onehot_decoder_pipe.sv
// onehot_decoder_pipe: registered SEL_WIDTH-to-OUT_COUNT one-hot decoder
// with a valid/ready handshake and a 2-entry skid buffer.
// Each accepted select word is decoded once, at accept time. The decoded
// strobe is then held in either the output register or the skid register
// until downstream consumes it.
// Optional feature macro: ONEHOT_DECODER_OOR_COUNT_EN adds an 8-bit saturating
// count (oor_count) of transferred words that had out_oor set.
module onehot_decoder_pipe #(
    parameter int SEL_WIDTH = 4,
    parameter int OUT_COUNT = 16,
    parameter int MASK_ZERO = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [SEL_WIDTH-1:0] sel,
    input  logic                 en,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_COUNT-1:0] onehot,
    output logic                 out_oor
`ifdef ONEHOT_DECODER_OOR_COUNT_EN
    ,
    output logic [7:0]           oor_count
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HOLD  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic                 accept;
    logic                 transfer;
    logic [OUT_COUNT-1:0] dec_onehot;
    logic                 dec_oor;
    logic [OUT_COUNT-1:0] skid_onehot;
    logic                 skid_oor;

    // Register-update controls produced by the FSM.
    logic load_out;    // output register <= fresh decode
    logic load_skid;   // skid register   <= fresh decode
    logic shift_skid;  // output register <= skid register
    logic clear_out;   // output register drained, drop stale strobe

    // Ready depends only on state and reset, so there is no ready path
    // from out_ready back to in_ready.
    assign in_ready  = !reset && (state != FULL);
    assign out_valid = (state != EMPTY);
    assign accept    = in_valid && in_ready;
    assign transfer  = out_valid && out_ready;

    // Decode the incoming select word. Out-of-range selects match no bit,
    // so the one-hot vector is all-zero whenever dec_oor is set.
    always_comb begin
        dec_onehot = '0;
        dec_oor    = en && (int'(sel) >= OUT_COUNT);
        for (int unsigned i = 0; i < OUT_COUNT; i++) begin
            dec_onehot[i] = en && (int'(sel) == int'(i)) && !((MASK_ZERO != 0) && (i == 0));
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and register-update control.
    always_comb begin
        state_next = state;
        load_out   = 1'b0;
        load_skid  = 1'b0;
        shift_skid = 1'b0;
        clear_out  = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    state_next = HOLD;
                    load_out   = 1'b1;
                end
            end
            HOLD: begin
                if (accept && transfer) begin
                    load_out = 1'b1;
                end else if (accept) begin
                    state_next = FULL;
                    load_skid  = 1'b1;
                end else if (transfer) begin
                    state_next = EMPTY;
                    clear_out  = 1'b1;
                end
            end
            FULL: begin
                if (transfer) begin
                    state_next = HOLD;
                    shift_skid = 1'b1;
                end
            end
            default: begin
                state_next = EMPTY;
            end
        endcase
    end

    // Output and skid data registers; reset discards any in-flight words.
    always_ff @(posedge clk) begin
        if (reset) begin
            onehot      <= '0;
            out_oor     <= 1'b0;
            skid_onehot <= '0;
            skid_oor    <= 1'b0;
        end else begin
            if (load_out) begin
                onehot  <= dec_onehot;
                out_oor <= dec_oor;
            end else if (shift_skid) begin
                onehot  <= skid_onehot;
                out_oor <= skid_oor;
            end else if (clear_out) begin
                onehot  <= '0;
                out_oor <= 1'b0;
            end
            if (load_skid) begin
                skid_onehot <= dec_onehot;
                skid_oor    <= dec_oor;
            end
        end
    end

`ifdef ONEHOT_DECODER_OOR_COUNT_EN
    // Saturating count of out-of-range words, bumped on the transfer edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            oor_count <= '0;
        end else if (transfer && out_oor && (oor_count != 8'hFF)) begin
            oor_count <= oor_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_onehot_decoder_pipe.sv
// Self-checking bench for onehot_decoder_pipe. Two instances share one
// stimulus stream: the default 16-output build and a 10-output build with
// output 0 masked. The reference model is a queue of accepted words; the
// expected outputs come from decoding the head of that queue.
module tb_onehot_decoder_pipe;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic [3:0] sel = '0;
    logic       en = 1'b0;
    logic       out_ready = 1'b0;

    logic        in_ready_a, out_valid_a, oor_a;
    logic [15:0] onehot_a;
    logic        in_ready_b, out_valid_b, oor_b;
    logic [9:0]  onehot_b;
`ifdef ONEHOT_DECODER_OOR_COUNT_EN
    logic [7:0]  cnt_a, cnt_b;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    onehot_decoder_pipe #(.SEL_WIDTH(4), .OUT_COUNT(16), .MASK_ZERO(0)) dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_a),
        .sel(sel), .en(en), .out_valid(out_valid_a), .out_ready(out_ready),
        .onehot(onehot_a), .out_oor(oor_a)
`ifdef ONEHOT_DECODER_OOR_COUNT_EN
        , .oor_count(cnt_a)
`endif
    );

    onehot_decoder_pipe #(.SEL_WIDTH(4), .OUT_COUNT(10), .MASK_ZERO(1)) dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_b),
        .sel(sel), .en(en), .out_valid(out_valid_b), .out_ready(out_ready),
        .onehot(onehot_b), .out_oor(oor_b)
`ifdef ONEHOT_DECODER_OOR_COUNT_EN
        , .oor_count(cnt_b)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int sel;
        bit en;
    } word_t;

    word_t q[$];
    int    cnt_exp_a = 0;
    int    cnt_exp_b = 0;
    bit    armed = 1'b0;

    function automatic logic [31:0] dec(input word_t w, input int n, input bit mz);
        logic [31:0] r = '0;
        if (w.en && w.sel < n && !(mz && w.sel == 0)) r = 32'd1 << w.sel;
        return r;
    endfunction

    function automatic logic oor(input word_t w, input int n);
        return w.en && (w.sel >= n);
    endfunction

    always @(posedge clk) begin
        word_t w, h;
        bit acc, xfer;
        if (reset) begin
            q.delete();
            cnt_exp_a = 0;
            cnt_exp_b = 0;
            armed = 1'b1;
        end else begin
            acc  = in_valid && (q.size() < 2);
            xfer = out_ready && (q.size() > 0);
            if (xfer) begin
                h = q.pop_front();
                if (oor(h, 16) && cnt_exp_a < 255) cnt_exp_a++;
                if (oor(h, 10) && cnt_exp_b < 255) cnt_exp_b++;
            end
            if (acc) begin
                w.sel = int'(sel);
                w.en  = en;
                q.push_back(w);
            end
        end
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        logic exp_ready;
        if (armed) begin
            exp_ready = !reset && (q.size() < 2);
            chk("in_ready_a", 32'(in_ready_a), 32'(exp_ready));
            chk("in_ready_b", 32'(in_ready_b), 32'(exp_ready));
            chk("out_valid_a", 32'(out_valid_a), 32'(q.size() > 0));
            chk("out_valid_b", 32'(out_valid_b), 32'(q.size() > 0));
            if (q.size() > 0) begin
                chk("onehot_a", 32'(onehot_a), dec(q[0], 16, 1'b0));
                chk("oor_a", 32'(oor_a), 32'(oor(q[0], 16)));
                chk("onehot_b", 32'(onehot_b), dec(q[0], 10, 1'b1));
                chk("oor_b", 32'(oor_b), 32'(oor(q[0], 10)));
            end
`ifdef ONEHOT_DECODER_OOR_COUNT_EN
            chk("oor_count_a", 32'(cnt_a), 32'(cnt_exp_a));
            chk("oor_count_b", 32'(cnt_b), 32'(cnt_exp_b));
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit r, input bit iv, input int s, input bit e, input bit ordy);
        @(posedge clk);
        #1;
        reset     = r;
        in_valid  = iv;
        sel       = 4'(s);
        en        = e;
        out_ready = ordy;
    endtask

    initial begin
        // Reset for three cycles.
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 0, 0);
            @(negedge clk);
            chk("rst_in_ready", 32'(in_ready_a), 32'd0);
            if (i > 0) begin
                chk("rst_out_valid", 32'(out_valid_a), 32'd0);
                chk("rst_onehot_a", 32'(onehot_a), 32'd0);
                chk("rst_oor_a", 32'(oor_a), 32'd0);
                chk("rst_onehot_b", 32'(onehot_b), 32'd0);
            end
        end
        drive(0, 0, 0, 0, 1);
        @(negedge clk);
        chk("post_rst_in_ready", 32'(in_ready_a), 32'd1);
        chk("post_rst_out_valid", 32'(out_valid_a), 32'd0);

        // Stream sel 0..15, one word per cycle, downstream always ready.
        for (int k = 0; k <= 16; k++) begin
            if (k < 16) drive(0, 1, k, 1, 1);
            else        drive(0, 0, 0, 0, 1);
            @(negedge clk);
            if (k > 0) begin
                chk("stream_onehot", 32'(onehot_a), 32'd1 << (k - 1));
                chk("stream_valid", 32'(out_valid_a), 32'd1);
                chk("stream_oor", 32'(oor_a), 32'd0);
            end
        end

        // Stall: two words pile up while downstream is stalled.
        drive(0, 1, 3, 1, 0);
        drive(0, 1, 9, 1, 0);
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("stall_full_ready", 32'(in_ready_a), 32'd0);
        chk("stall_onehot", 32'(onehot_a), 32'h0008);
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("stall_held", 32'(onehot_a), 32'h0008);
        drive(0, 0, 0, 0, 1);
        @(negedge clk);
        chk("unstall_first", 32'(onehot_a), 32'h0008);
        drive(0, 0, 0, 0, 1);
        @(negedge clk);
        chk("unstall_second", 32'(onehot_a), 32'h0200);
        chk("unstall_ready", 32'(in_ready_a), 32'd1);
        drive(0, 0, 0, 0, 1);

        // Out-of-range and masked zero, from a clean reset.
        drive(1, 0, 0, 0, 1);
        drive(0, 1, 12, 1, 1);
        drive(0, 1, 0, 1, 1);
        @(negedge clk);
        chk("oor12_b_flag", 32'(oor_b), 32'd1);
        chk("oor12_b_onehot", 32'(onehot_b), 32'd0);
        chk("sel12_a_onehot", 32'(onehot_a), 32'h1000);
`ifdef ONEHOT_DECODER_OOR_COUNT_EN
        chk("oor_cnt_before_xfer", 32'(cnt_b), 32'd0);
`endif
        drive(0, 1, 5, 1, 1);
        @(negedge clk);
        chk("mask0_b_onehot", 32'(onehot_b), 32'd0);
        chk("mask0_b_oor", 32'(oor_b), 32'd0);
        chk("sel0_a_onehot", 32'(onehot_a), 32'h0001);
`ifdef ONEHOT_DECODER_OOR_COUNT_EN
        chk("oor_cnt_after_xfer", 32'(cnt_b), 32'd1);
`endif
        drive(0, 0, 0, 0, 1);
        @(negedge clk);
        chk("sel5_b_onehot", 32'(onehot_b), 32'h020);
        drive(0, 0, 0, 0, 1);

        // en=0 word, then fill to FULL and reset mid-operation.
        drive(0, 1, 7, 0, 0);
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("en0_valid", 32'(out_valid_a), 32'd1);
        chk("en0_onehot_a", 32'(onehot_a), 32'd0);
        chk("en0_onehot_b", 32'(onehot_b), 32'd0);
        drive(0, 1, 2, 1, 0);
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("fill_full_ready", 32'(in_ready_a), 32'd0);
        drive(1, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 1);
        @(negedge clk);
        chk("midrst_valid", 32'(out_valid_a), 32'd0);
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0, 1);
            @(negedge clk);
            chk("midrst_no_strobe_v", 32'(out_valid_a), 32'd0);
            chk("midrst_no_strobe_a", 32'(onehot_a), 32'd0);
            chk("midrst_no_strobe_b", 32'(onehot_b), 32'd0);
        end

        // Randomised traffic with occasional reset.
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 99) == 0),
                  ($urandom_range(0, 3) != 0),
                  int'($urandom_range(0, 15)),
                  ($urandom_range(0, 7) != 0),
                  ($urandom_range(0, 2) != 0));
        end
        drive(0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 1);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
